// File: rtl/operand_bank_pkg.sv
// Shared encodings, reset constants and FSM state types for the operand bank.
package operand_bank_pkg;

  localparam logic [1:0] FIELD_M    = 2'd0;
  localparam logic [1:0] FIELD_E    = 2'd1;
  localparam logic [1:0] FIELD_N    = 2'd2;
  localparam logic [1:0] FIELD_RSVD = 2'd3;

  localparam logic [7:0] DEF_M = 8'h20;
  localparam logic [7:0] DEF_E = 8'h02;
  localparam logic [7:0] DEF_N = 8'h20;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_COMMIT  = 2'd2
  } wr_state_e;

  typedef enum logic {
    L_IDLE  = 1'b0,
    L_VALID = 1'b1
  } ln_state_e;

endpackage

// File: rtl/operand_bank_word_assembler.sv
// Collects bus words (LS word first) into one operand and pulses commit for a cycle.
module word_assembler
  import operand_bank_pkg::*;
#(
  parameter int DW     = 32,
  parameter int WIDTH  = 128,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [1:0]        wr_field,
  input  logic [DW-1:0]     wr_data,
  output logic              commit,
  output logic [SLOT_W-1:0] commit_slot,
  output logic [1:0]        commit_field,
  output logic [WIDTH-1:0]  commit_data
);

  localparam int WPO   = WIDTH / DW;
  localparam int CNT_W = $clog2(WPO + 1);

  wr_state_e          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   shift_r;
  logic [SLOT_W-1:0]  slot_r;
  logic [1:0]         field_r;
  logic               ready_r;

  // Write FSM: slot/field are captured only with the first word of an operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= W_IDLE;
      cnt_r   <= '0;
      shift_r <= '0;
      slot_r  <= '0;
      field_r <= 2'd0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        W_IDLE: begin
          if (wr_valid && ready_r) begin
            slot_r  <= wr_slot;
            field_r <= wr_field;
            shift_r <= WIDTH'(wr_data);
            cnt_r   <= CNT_W'(1);
            if (WPO == 1) begin
              state_r <= W_COMMIT;
              ready_r <= 1'b0;
            end else begin
              state_r <= W_COLLECT;
            end
          end
        end
        W_COLLECT: begin
          if (wr_valid) begin
            shift_r[int'(cnt_r)*DW +: DW] <= wr_data;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r + CNT_W'(1) == CNT_W'(WPO)) begin
              state_r <= W_COMMIT;
              ready_r <= 1'b0;
            end
          end
        end
        W_COMMIT: begin
          state_r <= W_IDLE;
          cnt_r   <= '0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= W_IDLE;
          cnt_r   <= '0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready     = ready_r;
  assign commit       = (state_r == W_COMMIT);
  assign commit_slot  = slot_r;
  assign commit_field = field_r;
  assign commit_data  = shift_r;

endmodule

// File: rtl/operand_bank.sv
// Writable bank of RSA operand sets; launches one set to the exponentiation core.
module operand_bank
  import operand_bank_pkg::*;
#(
  parameter int RSA_WIDTH          = 128,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_SLOTS          = 4,
  parameter int SLOT_W             = $clog2(NUM_SLOTS)
) (
  input  logic                          CLK_IN,
  input  logic                          RST_IN,
  input  logic                          WR_VALID_IN,
  output logic                          WR_READY_OUT,
  input  logic [SLOT_W-1:0]             WR_SLOT_IN,
  input  logic [1:0]                    WR_FIELD_IN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] WR_DATA_IN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] SELECT_IN,
  input  logic                          START_IN,
  output logic [RSA_WIDTH-1:0]          M_OUT,
  output logic [RSA_WIDTH-1:0]          E_OUT,
  output logic [RSA_WIDTH-1:0]          N_OUT,
  output logic                          OUT_VALID_OUT,
  input  logic                          OUT_READY_IN,
  output logic                          ERR_OUT
);

  logic                  commit_s;
  logic [SLOT_W-1:0]     commit_slot_s;
  logic [1:0]            commit_field_s;
  logic [RSA_WIDTH-1:0]  commit_data_s;

  logic [RSA_WIDTH-1:0]  m_r [NUM_SLOTS];
  logic [RSA_WIDTH-1:0]  e_r [NUM_SLOTS];
  logic [RSA_WIDTH-1:0]  n_r [NUM_SLOTS];

  ln_state_e             ln_state_r;
  logic                  launch_s;
  logic                  sel_oob_s;
  logic [SLOT_W-1:0]     sel_idx_s;

  word_assembler #(
    .DW     (C_S_AXI_DATA_WIDTH),
    .WIDTH  (RSA_WIDTH),
    .SLOT_W (SLOT_W)
  ) u_word_assembler (
    .clk          (CLK_IN),
    .rst          (RST_IN),
    .wr_valid     (WR_VALID_IN),
    .wr_ready     (WR_READY_OUT),
    .wr_slot      (WR_SLOT_IN),
    .wr_field     (WR_FIELD_IN),
    .wr_data      (WR_DATA_IN),
    .commit       (commit_s),
    .commit_slot  (commit_slot_s),
    .commit_field (commit_field_s),
    .commit_data  (commit_data_s)
  );

  // Launch decode: out-of-range selects fall back to slot 0.
  always_comb begin
    launch_s  = (ln_state_r == L_IDLE) && START_IN;
    sel_oob_s = (SELECT_IN >= C_S_AXI_DATA_WIDTH'(NUM_SLOTS));
    if (sel_oob_s) begin
      sel_idx_s = '0;
    end else begin
      sel_idx_s = SELECT_IN[SLOT_W-1:0];
    end
  end

  // Operand storage; the reserved field commits nothing.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        m_r[i] <= RSA_WIDTH'(DEF_M);
        e_r[i] <= RSA_WIDTH'(DEF_E);
        n_r[i] <= RSA_WIDTH'(DEF_N);
      end
    end else if (commit_s) begin
      case (commit_field_s)
        FIELD_M: m_r[commit_slot_s] <= commit_data_s;
        FIELD_E: e_r[commit_slot_s] <= commit_data_s;
        FIELD_N: n_r[commit_slot_s] <= commit_data_s;
        default: ;
      endcase
    end
  end

  // Launch FSM; a same-cycle commit is not visible to the launch (reads old storage).
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ln_state_r    <= L_IDLE;
      M_OUT         <= RSA_WIDTH'(DEF_M);
      E_OUT         <= RSA_WIDTH'(DEF_E);
      N_OUT         <= RSA_WIDTH'(DEF_N);
      OUT_VALID_OUT <= 1'b0;
    end else begin
      case (ln_state_r)
        L_IDLE: begin
          if (launch_s) begin
            M_OUT         <= m_r[sel_idx_s];
            E_OUT         <= e_r[sel_idx_s];
            N_OUT         <= n_r[sel_idx_s];
            OUT_VALID_OUT <= 1'b1;
            ln_state_r    <= L_VALID;
          end
        end
        L_VALID: begin
          if (OUT_READY_IN) begin
            OUT_VALID_OUT <= 1'b0;
            ln_state_r    <= L_IDLE;
          end
        end
        default: begin
          OUT_VALID_OUT <= 1'b0;
          ln_state_r    <= L_IDLE;
        end
      endcase
    end
  end

  // Sticky error: bad launch select or a commit to the reserved field.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ERR_OUT <= 1'b0;
    end else if ((launch_s && sel_oob_s) || (commit_s && commit_field_s == FIELD_RSVD)) begin
      ERR_OUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_bank.sv
// Self-checking bench for operand_bank: directed table, corner sequences and random ops vs a model.
module tb_operand_bank;

  localparam int RW = 128;
  localparam int DW = 32;
  localparam int NS = 4;

  logic          CLK_IN;
  logic          RST_IN;
  logic          WR_VALID_IN;
  logic          WR_READY_OUT;
  logic [1:0]    WR_SLOT_IN;
  logic [1:0]    WR_FIELD_IN;
  logic [DW-1:0] WR_DATA_IN;
  logic [DW-1:0] SELECT_IN;
  logic          START_IN;
  logic [RW-1:0] M_OUT;
  logic [RW-1:0] E_OUT;
  logic [RW-1:0] N_OUT;
  logic          OUT_VALID_OUT;
  logic          OUT_READY_IN;
  logic          ERR_OUT;

  operand_bank #(
    .RSA_WIDTH          (RW),
    .C_S_AXI_DATA_WIDTH (DW),
    .NUM_SLOTS          (NS)
  ) dut (
    .CLK_IN        (CLK_IN),
    .RST_IN        (RST_IN),
    .WR_VALID_IN   (WR_VALID_IN),
    .WR_READY_OUT  (WR_READY_OUT),
    .WR_SLOT_IN    (WR_SLOT_IN),
    .WR_FIELD_IN   (WR_FIELD_IN),
    .WR_DATA_IN    (WR_DATA_IN),
    .SELECT_IN     (SELECT_IN),
    .START_IN      (START_IN),
    .M_OUT         (M_OUT),
    .E_OUT         (E_OUT),
    .N_OUT         (N_OUT),
    .OUT_VALID_OUT (OUT_VALID_OUT),
    .OUT_READY_IN  (OUT_READY_IN),
    .ERR_OUT       (ERR_OUT)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arrays of whole operands plus the sticky error bit.
  logic [RW-1:0] mdl_m [NS];
  logic [RW-1:0] mdl_e [NS];
  logic [RW-1:0] mdl_n [NS];
  logic          mdl_err;
  int            checks;
  int            failures;

  typedef struct {
    logic [DW-1:0] sel;
    logic [RW-1:0] m;
    logic [RW-1:0] e;
    logic [RW-1:0] n;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NS; i++) begin
      mdl_m[i] = 128'h20;
      mdl_e[i] = 128'h2;
      mdl_n[i] = 128'h20;
    end
    mdl_err = 1'b0;
  endtask

  task automatic mdl_commit(input int slot, input int field, input logic [RW-1:0] val);
    case (field)
      0: mdl_m[slot] = val;
      1: mdl_e[slot] = val;
      2: mdl_n[slot] = val;
      default: mdl_err = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    RST_IN = 1'b1;
    WR_VALID_IN = 1'b0;
    START_IN = 1'b0;
    OUT_READY_IN = 1'b0;
    #2;
    RST_IN = 1'b0;
    mdl_reset();
  endtask

  task automatic send_word(input logic [1:0] slot, input logic [1:0] field,
                           input logic [DW-1:0] data, input int gap);
    logic hs;
    repeat (gap) begin
      @(posedge CLK_IN);
      #1;
    end
    WR_VALID_IN = 1'b1;
    WR_SLOT_IN  = slot;
    WR_FIELD_IN = field;
    WR_DATA_IN  = data;
    hs = 1'b0;
    for (int t = 0; t < 8 && !hs; t++) begin
      hs = WR_READY_OUT;
      @(posedge CLK_IN);
      #1;
    end
    WR_VALID_IN = 1'b0;
    chk("wr_accept", hs, 1'b1);
  endtask

  // Sends all four words; leaves the caller in the commit cycle.
  task automatic send_operand(input logic [1:0] slot, input logic [1:0] alt_slot,
                              input logic [1:0] field, input logic [RW-1:0] val, input bit gaps);
    for (int k = 0; k < RW / DW; k++) begin
      send_word((k == 0) ? slot : alt_slot, field, val[k*DW +: DW],
                gaps ? int'($urandom_range(0, 2)) : 0);
    end
    chk("wr_ready_commit", WR_READY_OUT, 1'b0);
  endtask

  task automatic write_operand(input logic [1:0] slot, input logic [1:0] alt_slot,
                               input logic [1:0] field, input logic [RW-1:0] val, input bit gaps);
    send_operand(slot, alt_slot, field, val, gaps);
    @(posedge CLK_IN);
    #1;
    chk("wr_ready_back", WR_READY_OUT, 1'b1);
    mdl_commit(int'(slot), int'(field), val);
  endtask

  task automatic launch_start(input logic [DW-1:0] sel);
    START_IN  = 1'b1;
    SELECT_IN = sel;
    @(posedge CLK_IN);
    #1;
    START_IN  = 1'b0;
    SELECT_IN = '0;
  endtask

  task automatic launch_release();
    OUT_READY_IN = 1'b1;
    @(posedge CLK_IN);
    #1;
    OUT_READY_IN = 1'b0;
    chk("valid_clear", OUT_VALID_OUT, 1'b0);
  endtask

  task automatic check_launch(input int idx);
    chk("out_valid", OUT_VALID_OUT, 1'b1);
    chk("m_out", M_OUT, mdl_m[idx]);
    chk("e_out", E_OUT, mdl_e[idx]);
    chk("n_out", N_OUT, mdl_n[idx]);
    chk("err_out", ERR_OUT, mdl_err);
  endtask

  task automatic do_launch(input logic [DW-1:0] sel);
    int idx;
    idx = (sel >= DW'(NS)) ? 0 : int'(sel);
    if (sel >= DW'(NS)) mdl_err = 1'b1;
    launch_start(sel);
    check_launch(idx);
    launch_release();
  endtask

  initial begin
    logic [RW-1:0] new_n;
    checks = 0;
    failures = 0;
    RST_IN = 1'b1;
    WR_VALID_IN = 1'b0;
    WR_SLOT_IN = 2'd0;
    WR_FIELD_IN = 2'd0;
    WR_DATA_IN = '0;
    SELECT_IN = '0;
    START_IN = 1'b0;
    OUT_READY_IN = 1'b0;
    mdl_reset();
    repeat (2) @(posedge CLK_IN);
    #1;
    RST_IN = 1'b0;

    // Reset state
    chk("rst_m", M_OUT, 128'h20);
    chk("rst_e", E_OUT, 128'h2);
    chk("rst_n", N_OUT, 128'h20);
    chk("rst_valid", OUT_VALID_OUT, 1'b0);
    chk("rst_err", ERR_OUT, 1'b0);
    chk("rst_ready", WR_READY_OUT, 1'b1);

    // Launch slot 2 after reset and hold without ready
    launch_start(32'd2);
    check_launch(2);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK_IN);
      #1;
      chk("hold_valid", OUT_VALID_OUT, 1'b1);
      chk("hold_m", M_OUT, 128'h20);
      chk("hold_e", E_OUT, 128'h2);
      chk("hold_n", N_OUT, 128'h20);
    end
    launch_release();

    // Slot 1 M word order
    write_operand(2'd1, 2'd1, 2'd0, 128'h00000004_00000003_00000002_00000001, 1'b0);
    launch_start(32'd1);
    chk("s1_m_literal", M_OUT, 128'h00000004_00000003_00000002_00000001);
    chk("s1_e_default", E_OUT, 128'h2);
    chk("s1_n_default", N_OUT, 128'h20);
    launch_release();

    // Slot 0 E with gaps; slot input changes to 3 after the first word
    write_operand(2'd0, 2'd3, 2'd1, 128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000, 1'b1);
    do_launch(32'd0);
    do_launch(32'd3);

    // Table-driven launches over a fresh bank
    do_reset();
    write_operand(2'd0, 2'd0, 2'd0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
    write_operand(2'd2, 2'd2, 2'd1, 128'hffff0000_12345678_9abcdef0_00000001, 1'b0);
    write_operand(2'd3, 2'd3, 2'd2, 128'h80000000_00000000_00000000_00000001, 1'b0);
    write_operand(2'd3, 2'd3, 2'd0, 128'hdeadbeef_cafef00d_0badc0de_13579bdf, 1'b0);
    tbl[0] = '{32'd0, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h2, 128'h20};
    tbl[1] = '{32'd1, 128'h20, 128'h2, 128'h20};
    tbl[2] = '{32'd2, 128'h20, 128'hffff0000_12345678_9abcdef0_00000001, 128'h20};
    tbl[3] = '{32'd3, 128'hdeadbeef_cafef00d_0badc0de_13579bdf, 128'h2,
               128'h80000000_00000000_00000000_00000001};
    for (int i = 0; i < 4; i++) begin
      launch_start(tbl[i].sel);
      chk("tbl_valid", OUT_VALID_OUT, 1'b1);
      chk("tbl_m", M_OUT, tbl[i].m);
      chk("tbl_e", E_OUT, tbl[i].e);
      chk("tbl_n", N_OUT, tbl[i].n);
      chk("tbl_err", ERR_OUT, 1'b0);
      launch_release();
    end

    // Launch in the commit cycle of slot 2 N sees the old value
    new_n = 128'h13572468_0f0f0f0f_f0f0f0f0_00c0ffee;
    send_operand(2'd2, 2'd2, 2'd2, new_n, 1'b0);
    launch_start(32'd2);
    check_launch(2);
    chk("collide_n_old", N_OUT, 128'h20);
    mdl_commit(2, 2, new_n);
    chk("collide_ready", WR_READY_OUT, 1'b1);
    launch_release();
    do_launch(32'd2);

    // Asynchronous reset clears outputs without a clock edge
    launch_start(32'd3);
    RST_IN = 1'b1;
    #1;
    chk("async_valid", OUT_VALID_OUT, 1'b0);
    chk("async_m", M_OUT, 128'h20);
    RST_IN = 1'b0;
    mdl_reset();

    // Reset mid-operand discards the partial buffer
    send_word(2'd2, 2'd2, 32'h11111111, 0);
    send_word(2'd2, 2'd2, 32'h22222222, 0);
    do_reset();
    do_launch(32'd2);
    write_operand(2'd2, 2'd2, 2'd2, 128'h44444444_33333333_22222222_11111111, 1'b0);
    do_launch(32'd2);

    // Reserved field: nothing stored, error set
    write_operand(2'd1, 2'd1, 2'd3, 128'h99999999_88888888_77777777_66666666, 1'b0);
    chk("rsvd_err", ERR_OUT, 1'b1);
    do_launch(32'd1);
    do_launch(32'd2);

    // Out-of-range select and START ignored while valid
    do_reset();
    write_operand(2'd1, 2'd1, 2'd0, 128'h01010101_02020202_03030303_04040404, 1'b0);
    mdl_err = 1'b1;
    launch_start(32'd7);
    check_launch(0);
    launch_start(32'd1);
    check_launch(0);
    launch_release();
    do_launch(32'd1);
    chk("err_sticky", ERR_OUT, 1'b1);

    // Random operations against the model
    do_reset();
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 2) < 2) begin
        logic [1:0] s;
        logic [1:0] a;
        logic [1:0] f;
        s = 2'($urandom_range(0, 3));
        a = 2'($urandom_range(0, 3));
        f = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        write_operand(s, a, f, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        chk("rnd_err", ERR_OUT, mdl_err);
      end else begin
        do_launch(DW'($urandom_range(0, 5)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
